// File: rtl/ram_arbiter.sv
// Two-port (CPU / DMA) round-robin arbiter for a nibble-wide asynchronous RAM.
// Every RAM-facing output is a flop, so the strobes are glitch-free.
module ram_arbiter #(
  parameter int STRB_CYCLES = 1
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       c_req,
  input  logic       c_we,
  input  logic [7:0] c_addr,
  input  logic [3:0] c_wdata,
  output logic       c_ack,
  output logic [3:0] c_rdata,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [3:0] d_wdata,
  output logic       d_ack,
  output logic [3:0] d_rdata,
  output logic [7:0] address_bus,
  output logic [3:0] ram_dout,
  output logic       ram_doe,
  input  logic [3:0] ram_din,
  output logic       nRAM_RD,
  output logic       nRAM_WR,
  output logic       busy,
  output logic       grant_d
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(STRB_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic       gnt_q, gnt_d;
  logic       last_dma_q, last_dma_d;
  logic [7:0] addr_q, addr_d;
  logic [3:0] wdata_q, wdata_d;
  logic       doe_q, doe_d;
  logic       nrd_q, nrd_d;
  logic       nwr_q, nwr_d;
  logic [3:0] c_rdata_q, c_rdata_d;
  logic [3:0] d_rdata_q, d_rdata_d;
  logic       c_ack_q, c_ack_d;
  logic       d_ack_q, d_ack_d;
  logic       pick_dma;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    gnt_d      = gnt_q;
    last_dma_d = last_dma_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    doe_d      = doe_q;
    nrd_d      = nrd_q;
    nwr_d      = nwr_q;
    c_rdata_d  = c_rdata_q;
    d_rdata_d  = d_rdata_q;
    c_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    // DMA wins only when alone or when the CPU was served last
    pick_dma   = d_req & (~c_req | ~last_dma_q);

    case (state_q)
      IDLE: begin
        if (c_req | d_req) begin
          state_d    = SETUP;
          gnt_d      = pick_dma;
          last_dma_d = pick_dma;
          we_d       = pick_dma ? d_we : c_we;
          addr_d     = pick_dma ? d_addr : c_addr;
          wdata_d    = we_d ? (pick_dma ? d_wdata : c_wdata) : 4'h0;
          doe_d      = we_d;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'h0;
        nrd_d   = we_q;
        nwr_d   = ~we_q;
      end
      STROBE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = 4'h0;
          nrd_d   = 1'b1;
          nwr_d   = 1'b1;
          if (gnt_q) d_ack_d = 1'b1;
          else       c_ack_d = 1'b1;
          if (!we_q) begin
            if (gnt_q) d_rdata_d = ram_din;
            else       c_rdata_d = ram_din;
          end
        end else begin
          cnt_d = cnt_q + 4'h1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = 8'h00;
        wdata_d = 4'h0;
        doe_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'h0;
      we_q       <= 1'b0;
      gnt_q      <= 1'b0;
      last_dma_q <= 1'b1;
      addr_q     <= 8'h00;
      wdata_q    <= 4'h0;
      doe_q      <= 1'b0;
      nrd_q      <= 1'b1;
      nwr_q      <= 1'b1;
      c_rdata_q  <= 4'h0;
      d_rdata_q  <= 4'h0;
      c_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      gnt_q      <= gnt_d;
      last_dma_q <= last_dma_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      doe_q      <= doe_d;
      nrd_q      <= nrd_d;
      nwr_q      <= nwr_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
      c_ack_q    <= c_ack_d;
      d_ack_q    <= d_ack_d;
    end
  end

  assign c_ack       = c_ack_q;
  assign d_ack       = d_ack_q;
  assign c_rdata     = c_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign address_bus = addr_q;
  assign ram_dout    = wdata_q;
  assign ram_doe     = doe_q;
  assign nRAM_RD     = nrd_q;
  assign nRAM_WR     = nwr_q;
  assign busy        = (state_q != IDLE);
  assign grant_d     = gnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: random two-port traffic against a RAM model,
// plus a STRB_CYCLES=3 instance for strobe-length and latency.
module tb_ram_arbiter;
  localparam int S1 = 1;
  localparam int S3 = 3;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [7:0] c_addr = 8'h00, d_addr = 8'h00;
  logic [3:0] c_wdata = 4'h0, d_wdata = 4'h0;
  logic       c_ack, d_ack, ram_doe, nRAM_RD, nRAM_WR, busy, grant_d;
  logic [3:0] c_rdata, d_rdata, ram_dout, ram_din;
  logic [7:0] address_bus;

  logic       c_req3 = 1'b0, c_we3 = 1'b0;
  logic [7:0] c_addr3 = 8'h00;
  logic [3:0] c_wdata3 = 4'h0;
  logic       z1 = 1'b0;
  logic [7:0] z8 = 8'h00;
  logic [3:0] z4 = 4'h0;
  logic       c_ack3, d_ack3, ram_doe3, nRAM_RD3, nRAM_WR3, busy3, grant_d3;
  logic [3:0] c_rdata3, d_rdata3, ram_dout3, ram_din3;
  logic [7:0] address_bus3;

  always #5 clk = ~clk;

  ram_arbiter #(.STRB_CYCLES(S1)) dut (
    .clk(clk), .nReset(nReset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .address_bus(address_bus), .ram_dout(ram_dout), .ram_doe(ram_doe), .ram_din(ram_din),
    .nRAM_RD(nRAM_RD), .nRAM_WR(nRAM_WR), .busy(busy), .grant_d(grant_d));

  ram_arbiter #(.STRB_CYCLES(S3)) dut3 (
    .clk(clk), .nReset(nReset),
    .c_req(c_req3), .c_we(c_we3), .c_addr(c_addr3), .c_wdata(c_wdata3), .c_ack(c_ack3), .c_rdata(c_rdata3),
    .d_req(z1), .d_we(z1), .d_addr(z8), .d_wdata(z4), .d_ack(d_ack3), .d_rdata(d_rdata3),
    .address_bus(address_bus3), .ram_dout(ram_dout3), .ram_doe(ram_doe3), .ram_din(ram_din3),
    .nRAM_RD(nRAM_RD3), .nRAM_WR(nRAM_WR3), .busy(busy3), .grant_d(grant_d3));

  assign ram_din3 = 4'h9;

  // Asynchronous-read RAM behind the arbiter; written on each clock of a write strobe.
  logic [3:0] mem [256];
  logic       mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= 4'h0;
    else if (!nRAM_WR) mem[address_bus] <= ram_dout;
  end
  assign ram_din = mem[address_bus];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [3:0] wdata;
    logic [3:0] rd;
  } sb_t;

  sb_t        q_c[$];
  sb_t        q_d[$];
  logic [3:0] ref_mem [256];

  // Request inputs as seen by the DUT at each rising edge.
  logic       s_creq, s_dreq, s_cwe, s_dwe;
  logic [7:0] s_caddr, s_daddr;
  always @(posedge clk) begin
    s_creq <= c_req; s_dreq <= d_req; s_cwe <= c_we; s_dwe <= d_we;
    s_caddr <= c_addr; s_daddr <= d_addr;
  end

  logic       in_xfer = 1'b0, last_dma_m = 1'b1, gnt_p = 1'b0, gnt_we = 1'b0, ep = 1'b0;
  logic [7:0] gnt_addr = 8'h00;
  logic [3:0] cur_rd_c = 4'h0, cur_rd_d = 4'h0;
  int         cyc = 0, strb_cnt = 0;
  sb_t        mon_e;

  always @(negedge clk) begin
    if (!nReset) begin
      in_xfer = 1'b0; last_dma_m = 1'b1; cur_rd_c = 4'h0; cur_rd_d = 4'h0;
    end else begin
      check("no_dual_strobe", 32'(!nRAM_RD && !nRAM_WR), 32'd0);
      check("doe_during_read", 32'(ram_doe && !nRAM_RD), 32'd0);
      if (!busy) check("idle_addr", 32'(address_bus), 32'd0);
      if (!ram_doe) check("dout_off", 32'(ram_dout), 32'd0);
      if (busy && !in_xfer) begin
        ep = s_dreq && (!s_creq || !last_dma_m);
        check("grant_port", 32'(grant_d), 32'(ep));
        gnt_p = ep;
        gnt_addr = ep ? s_daddr : s_caddr;
        gnt_we = ep ? s_dwe : s_cwe;
        check("setup_addr", 32'(address_bus), 32'(gnt_addr));
        check("setup_doe", 32'(ram_doe), 32'(gnt_we));
        last_dma_m = ep; in_xfer = 1'b1; cyc = 0; strb_cnt = 0;
      end else if (in_xfer) begin
        cyc++;
      end
      if (in_xfer && (!nRAM_RD || !nRAM_WR)) strb_cnt++;
      if (c_ack || d_ack) begin
        check("ack_port", 32'({c_ack, d_ack}), gnt_p ? 32'd1 : 32'd2);
        check("ack_latency", 32'(cyc), 32'(S1 + 1));
        check("strobe_len", 32'(strb_cnt), 32'(S1));
        if ((gnt_p ? q_d.size() : q_c.size()) == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_ack: port %0d acked with no pending request", gnt_p);
        end else begin
          mon_e = gnt_p ? q_d.pop_front() : q_c.pop_front();
          check("done_addr", 32'(address_bus), 32'(mon_e.addr));
          check("done_doe", 32'(ram_doe), 32'(mon_e.we));
          if (mon_e.we) check("ram_written", 32'(mem[mon_e.addr]), 32'(mon_e.wdata));
          else if (gnt_p) cur_rd_d = mon_e.rd;
          else cur_rd_c = mon_e.rd;
        end
        check("c_rdata", 32'(c_rdata), 32'(cur_rd_c));
        check("d_rdata", 32'(d_rdata), 32'(cur_rd_d));
        in_xfer = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (nReset) begin
      check("dut3_no_dual_strobe", 32'(!nRAM_RD3 && !nRAM_WR3), 32'd0);
      check("dut3_doe_during_read", 32'(ram_doe3 && !nRAM_RD3), 32'd0);
    end
  end

  task automatic drive(input bit p, input logic r, input logic w, input logic [7:0] a, input logic [3:0] d);
    if (p) begin d_req = r; d_we = w; d_addr = a; d_wdata = d; end
    else begin c_req = r; c_we = w; c_addr = a; c_wdata = d; end
  endtask

  // Called at a negedge; returns at the negedge where req has been dropped.
  task automatic xfer(input bit p, input logic we, input logic [7:0] a, input logic [3:0] w);
    sb_t e;
    bit  scr;
    int  n;
    e.we = we; e.addr = a; e.wdata = w; e.rd = ref_mem[a];
    if (we) ref_mem[a] = w;
    if (p) q_d.push_back(e); else q_c.push_back(e);
    drive(p, 1'b1, we, a, w);
    scr = 1'b0; n = 0;
    do begin
      @(negedge clk); n++;
      if (!scr && busy && grant_d == p && address_bus == a) begin
        drive(p, 1'b1, ~we, 8'($urandom), 4'($urandom));
        scr = 1'b1;
      end
    end while (!(p ? d_ack : c_ack) && n < 40);
    check("ack_timeout", 32'(n < 40), 32'd1);
    @(negedge clk);
    drive(p, 1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  task automatic gap_check(input bit first_dma);
    int k = 0;
    while (!(first_dma ? d_ack : c_ack) && k < 20) begin @(negedge clk); k++; end
    check("first_served", 32'(first_dma ? d_ack : c_ack), 32'd1);
    @(negedge clk);
    check("gap_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("gap_next", 32'({busy, grant_d}), 32'({1'b1, ~first_dma}));
  endtask

  initial begin
    int k, nl;
    for (int i = 0; i < 256; i++) ref_mem[i] = 4'h0;
    repeat (2) @(posedge clk);
    mem_clr = 1'b0;
    #1;
    check("rst_nrd", 32'(nRAM_RD), 32'd1);
    check("rst_nwr", 32'(nRAM_WR), 32'd1);
    check("rst_outs", 32'({ram_doe, ram_dout, address_bus, c_ack, d_ack, busy, grant_d}), 32'd0);
    check("rst_rdata", 32'({c_rdata, d_rdata}), 32'd0);
    check("rst_dut3", 32'({nRAM_RD3, nRAM_WR3, busy3}), 32'd6);
    @(negedge clk); nReset = 1'b1;
    @(negedge clk);

    xfer(1'b0, 1'b1, 8'hF2, 4'hA);
    xfer(1'b1, 1'b0, 8'hF2, 4'h0);
    check("dma_readback", 32'(d_rdata), 32'hA);
    check("cpu_rdata_kept", 32'(c_rdata), 32'h0);
    xfer(1'b0, 1'b1, 8'h11, 4'h3);
    fork
      xfer(1'b0, 1'b1, 8'h10, 4'h5);
      xfer(1'b1, 1'b1, 8'h90, 4'h6);
      gap_check(1'b1);
    join

    // Reset during the strobe of a write must release nRAM_WR at once.
    drive(1'b0, 1'b1, 1'b1, 8'h33, 4'h7);
    k = 0;
    while (nRAM_WR && k < 10) begin @(negedge clk); k++; end
    check("mid_wr_strobe", 32'(nRAM_WR), 32'd0);
    #2 nReset = 1'b0;
    #1;
    check("async_nwr", 32'(nRAM_WR), 32'd1);
    check("async_outs", 32'({busy, ram_doe, address_bus, c_ack}), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    @(negedge clk);
    @(posedge clk); #2 nReset = 1'b1;
    @(negedge clk);
    check("no_ack_after_abort", 32'(c_ack), 32'd0);
    fork
      xfer(1'b0, 1'b0, 8'h10, 4'h0);
      xfer(1'b1, 1'b0, 8'h90, 4'h0);
      gap_check(1'b0);
    join

    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        xfer(1'b0, 1'($urandom), {5'b00000, 3'($urandom)}, 4'($urandom));
      end
      for (int j = 0; j < 30; j++) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        xfer(1'b1, 1'($urandom), {5'b10000, 3'($urandom)}, 4'($urandom));
      end
    join
    check("queues_drained", 32'(q_c.size() + q_d.size()), 32'd0);

    @(negedge clk);
    c_req3 = 1'b1; c_we3 = 1'b0; c_addr3 = 8'h5A;
    k = 0; nl = 0;
    while (!c_ack3 && k < 20) begin @(negedge clk); k++; if (!nRAM_RD3) nl++; end
    check("s3_rd_ack_latency", 32'(k), 32'd5);
    check("s3_rd_strobe_len", 32'(nl), 32'd3);
    check("s3_rdata", 32'(c_rdata3), 32'h9);
    check("s3_addr", 32'(address_bus3), 32'h5A);
    @(negedge clk);
    c_req3 = 1'b0;
    @(negedge clk);
    c_req3 = 1'b1; c_we3 = 1'b1; c_addr3 = 8'hC3; c_wdata3 = 4'h4;
    k = 0; nl = 0;
    while (!c_ack3 && k < 20) begin
      @(negedge clk); k++;
      if (!nRAM_WR3) begin nl++; check("s3_wr_dout", 32'({ram_doe3, ram_dout3}), 32'h14); end
    end
    check("s3_wr_ack_latency", 32'(k), 32'd5);
    check("s3_wr_strobe_len", 32'(nl), 32'd3);
    check("s3_wr_keeps_rdata", 32'(c_rdata3), 32'h9);
    @(negedge clk);
    c_req3 = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STRB_CYCLES, default 1, SHALL set the number of cycles a RAM strobe is held low (legal 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 nReset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 c_req, c_we  input  1 each  SHALL be the CPU port request and write select (1 = write).
REQ-005 c_addr  input  8; c_wdata  input  4  SHALL be the CPU port nibble address and write data.
REQ-006 c_ack  output  1; c_rdata  output  4  SHALL be the CPU port completion pulse and read data.
REQ-007 d_req, d_we, d_addr[7:0], d_wdata[3:0], d_ack, d_rdata[3:0]  SHALL be the DMA/debug port, identical in direction, width and meaning to REQ-004..006.
REQ-008 address_bus  output  8  SHALL drive the RAM address.
REQ-009 ram_dout  output  4; ram_doe  output  1; ram_din  input  4  SHALL be the split RAM data bus: write data, write-data output enable, read data.
REQ-010 nRAM_RD, nRAM_WR  output  1 each  SHALL be the active-low RAM read and write strobes.
REQ-011 busy  output  1; grant_d  output  1  SHALL flag that a transfer is in progress (state != IDLE) and which port owns it (1 = DMA).

Function
REQ-012 The FSM SHALL have states IDLE, SETUP, STROBE, DONE.
REQ-013 IDLE: if any req is high, SHALL pick a port, latch its we/addr/wdata and move to SETUP; otherwise SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: with one requester, that port wins; with both, the port not served last wins.
REQ-015 SETUP SHALL last exactly 1 cycle, then move to STROBE.
REQ-016 STROBE SHALL last exactly STRB_CYCLES cycles, counted by a 4-bit counter, then move to DONE.
REQ-017 DONE SHALL last 1 cycle, assert the granted port's ack for that single cycle, then return to IDLE.
REQ-018 With STRB_CYCLES=1, req sampled high at edge N SHALL give SETUP in cycle N+1, STROBE in N+2, ack in N+3, IDLE in N+4.
REQ-019 address_bus SHALL hold the latched address through SETUP, STROBE and DONE, and SHALL be 8'h00 in IDLE.
REQ-020 nRAM_RD SHALL be low only in STROBE of a read; nRAM_WR SHALL be low only in STROBE of a write; the two SHALL never be low together.
REQ-021 Strobes SHALL come directly from registered state, so no combinational glitches occur.
REQ-022 ram_doe SHALL be high and ram_dout SHALL hold the latched wdata during SETUP, STROBE and DONE of a write; otherwise ram_doe=0 and ram_dout=4'h0.
REQ-023 For a read, ram_din SHALL be captured into the granted port's rdata on the edge that ends the last STROBE cycle; rdata SHALL be valid when ack is high and hold until that port's next read.
REQ-024 A write SHALL leave both rdata registers unchanged.
REQ-025 Requesters SHALL hold req until ack and drop it in the cycle after ack; DONE→IDLE guarantees a held req is never double-served.
REQ-026 Changes to addr, we or wdata after grant SHALL NOT affect the transfer in progress.
REQ-027 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the transfer.
REQ-028 A port's req asserted during another port's transfer SHALL be granted at the next IDLE, giving at most one transfer of waiting.

Reset
REQ-029 nReset low SHALL immediately, without waiting for clk, force state=IDLE, nRAM_RD=nRAM_WR=1, ram_doe=0, ram_dout=4'h0, address_bus=8'h00, c_ack=d_ack=0, c_rdata=d_rdata=4'h0, busy=0, grant_d=0, and strobe counter=0.
REQ-030 Reset SHALL mark the DMA port as last served, so the CPU wins the first contention.
REQ-031 Reset during STROBE SHALL abort the transfer with no ack; the RAM contents of that address are then undefined to the requester.

Verification
REQ-032 CPU write: c_req=1, c_we=1, c_addr=F2, c_wdata=A -> address_bus=F2 and ram_doe=1 from SETUP; one-cycle nRAM_WR low; c_ack at cycle 3 after the sampling edge; RAM[F2]=A.
REQ-033 DMA read back: d_req, d_we=0, d_addr=F2 -> one-cycle nRAM_RD low; d_rdata=A when d_ack=1; c_rdata unchanged.
REQ-034 Both ports request on the same edge after reset -> CPU served first, DMA second; a second simultaneous request -> DMA served first; busy stays high except for one IDLE cycle between transfers.
REQ-035 STRB_CYCLES=3 -> strobe low for exactly 3 cycles; ack 5 cycles after the sampling edge.
REQ-036 nReset pulsed low mid-STROBE of a write -> nRAM_WR rises before the next clk edge; no ack; the next request completes normally.
REQ-037 Bench assertion throughout all scenarios -> nRAM_RD and nRAM_WR are never low together, and ram_doe is never high while nRAM_RD is low.
